// File: rtl/fpga_tt_harness_pkg.sv
// Shared constants and helpers for the TinyTapeout FPGA harness.
// Holds the active-high hex-to-seven-segment table, the blank segment
// pattern and the counter-width helper used to size every counter.
package fpga_tt_harness_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by nibble value.
  // Index 15 is listed first; 'b' and 'd' use the lower-case shapes.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // All segments dark, active-high sense.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Bits needed for a counter holding 0..max_count-1 (never less than 1).
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/fpga_tt_harness_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for one raw input.
// The stable value only flips once the synced input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles.
module fpga_tt_debounce
  import fpga_tt_harness_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count disagreement cycles; any agreement clears the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser chain and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/fpga_tt_harness.sv
// Board-side harness around a TinyTapeout-style DUT: synchronises and
// debounces switches, stretches the DUT reset, gates uio pads by the DUT
// output enables and scans a multi-digit hex seven-segment display.
// Optional single-step button: define FPGA_TT_HARNESS_STEP_EN.
module fpga_tt_harness
  import fpga_tt_harness_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RST_STRETCH     = 16,
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_CYCLES  = 1000,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SW-1:0]       sw_i,
`ifdef FPGA_TT_HARNESS_STEP_EN
  input  logic                    step_i,
`endif
  input  logic [7:0]              pmod_i,
  input  logic [7:0]              uio_pad_i,
  output logic [7:0]              uio_pad_o,
  output logic [7:0]              ui_in_o,
  output logic [7:0]              uio_in_o,
  input  logic [7:0]              uio_out_i,
  input  logic [7:0]              uio_oe_i,
  output logic                    dut_rst_n_o,
  output logic                    dut_ena_o,
  input  logic [4*NUM_DIGITS-1:0] disp_val_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o
);

  localparam int RST_W = cnt_width(RST_STRETCH + 1);
  localparam logic [RST_W-1:0] RST_DONE = RST_W'(RST_STRETCH);
  localparam int REF_W = cnt_width(REFRESH_CYCLES);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_IDLE = ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = ACT_LOW ? '1 : '0;

  // ---------------- switches ----------------
  logic [NUM_SW-1:0] sw_db;

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
      fpga_tt_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (sw_i[gi]),
        .stable_o(sw_db[gi])
      );
    end
  endgenerate

  // ---------------- pmod / uio ----------------
  logic [7:0] pmod_s1_q, pmod_s2_q, pad_s1_q, pad_s2_q;
  logic [7:0] uio_in_q, uio_in_d;

  // Bits the DUT is driving read back as 0 on its input side.
  assign uio_in_d = pad_s2_q & ~uio_oe_i;

  // Pad synchronisers and registered uio input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmod_s1_q <= '0;
      pmod_s2_q <= '0;
      pad_s1_q  <= '0;
      pad_s2_q  <= '0;
      uio_in_q  <= '0;
    end else begin
      pmod_s1_q <= pmod_i;
      pmod_s2_q <= pmod_s1_q;
      pad_s1_q  <= uio_pad_i;
      pad_s2_q  <= pad_s1_q;
      uio_in_q  <= uio_in_d;
    end
  end

  assign ui_in_o   = pmod_s2_q;
  assign uio_in_o  = uio_in_q;
  assign uio_pad_o = uio_out_i & uio_oe_i;

  // ---------------- reset stretch and enable ----------------
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             dut_rst_n_q, dut_rst_n_d;
  logic             dut_ena_q, dut_ena_d;
  logic             run_req;

  // Hold the DUT in reset while sw[0] is on, then count out the stretch.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    dut_rst_n_d = dut_rst_n_q;
    if (sw_db[0]) begin
      rst_cnt_d   = '0;
      dut_rst_n_d = 1'b0;
    end else if (!dut_rst_n_q) begin
      rst_cnt_d = rst_cnt_q + RST_W'(1);
      if (rst_cnt_d == RST_DONE) begin
        dut_rst_n_d = 1'b1;
      end
    end
  end

`ifdef FPGA_TT_HARNESS_STEP_EN
  logic step_db, step_prev_q, step_prev_d;

  fpga_tt_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (step_i),
    .stable_o(step_db)
  );

  assign step_prev_d = step_db;

  // Remember the previous debounced button level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
    end
  end

  // Free-run on sw[1]; otherwise one enable cycle per button press.
  assign run_req = sw_db[1] | (step_db & ~step_prev_q);
`else
  assign run_req = sw_db[1];
`endif

  assign dut_ena_d = run_req & dut_rst_n_q;

  // Stretcher and enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q   <= '0;
      dut_rst_n_q <= 1'b0;
      dut_ena_q   <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_ena_q   <= dut_ena_d;
    end
  end

  assign dut_rst_n_o = dut_rst_n_q;
  assign dut_ena_o   = dut_ena_q;

  // ---------------- display scan ----------------
  logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d, dig_onehot;
  logic [3:0]            nibble;

  // On each refresh wrap, latch the current digit's pattern and step on.
  always_comb begin
    nibble = disp_val_i[{dig_idx_q, 2'b00} +: 4];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_onehot[i] = (dig_idx_q == IDX_W'(i));
    end
    ref_cnt_d = ref_cnt_q + REF_W'(1);
    dig_idx_d = dig_idx_q;
    seg_d     = seg_q;
    dig_sel_d = dig_sel_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
      seg_d     = ACT_LOW ? ~HEX_SEG[nibble] : HEX_SEG[nibble];
      dig_sel_d = ACT_LOW ? ~dig_onehot : dig_onehot;
    end
  end

  // Display registers; segments and select always move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
      dig_idx_q <= '0;
      seg_q     <= SEG_IDLE;
      dig_sel_q <= DIG_IDLE;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      dig_idx_q <= dig_idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg_o     = seg_q;
  assign dig_sel_o = dig_sel_q;

endmodule

// File: tb/tb_fpga_tt_harness.sv
// Self-checking bench for fpga_tt_harness (DEBOUNCE_CYCLES=8, RST_STRETCH=16,
// 4 digits, REFRESH_CYCLES=4, active-low display).  Every output is compared
// each cycle against a history-window reference model; fixed vectors cover
// the reset release, display scan, debounce, stretch restart and uio cases.
`timescale 1ns/1ps
module tb_fpga_tt_harness;

  localparam int DEB     = 8;
  localparam int STRETCH = 16;
  localparam int ND      = 4;
  localparam int REFR    = 4;
  localparam int HN      = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sw = '0;
  logic        step = 1'b0;
  logic [7:0]  pmod = '0, pad = '0, uout = '0, oe = '0;
  logic [15:0] disp = '0;

  logic [7:0]  uio_pad_o, ui_in_o, uio_in_o;
  logic        dut_rst_n_o, dut_ena_o;
  logic [6:0]  seg_o;
  logic [3:0]  dig_sel_o;

  always #5 clk = ~clk;

  fpga_tt_harness #(
    .NUM_SW(2), .DEBOUNCE_CYCLES(DEB), .RST_STRETCH(STRETCH),
    .NUM_DIGITS(ND), .REFRESH_CYCLES(REFR), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_i(sw),
`ifdef FPGA_TT_HARNESS_STEP_EN
    .step_i(step),
`endif
    .pmod_i(pmod), .uio_pad_i(pad), .uio_pad_o(uio_pad_o), .ui_in_o(ui_in_o),
    .uio_in_o(uio_in_o), .uio_out_i(uout), .uio_oe_i(oe),
    .dut_rst_n_o(dut_rst_n_o), .dut_ena_o(dut_ena_o), .disp_val_i(disp),
    .seg_o(seg_o), .dig_sel_o(dig_sel_o)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;   // clock edges since the last reset release

  // Inputs held before edge m, and model state after edge m.
  logic [1:0]  sw_h [HN];
  logic        step_h [HN];
  logic [7:0]  pmod_h [HN], pad_h [HN], oe_h [HN];
  logic [15:0] disp_h [HN];
  logic [1:0]  db_h [HN];
  logic        sdb_h [HN];
  logic        rst_h [HN];
  logic [6:0]  seg_m;
  logic [3:0]  dig_m;
  logic [6:0]  hex_tab [16];

  typedef struct { int at; logic [3:0] dig; logic [6:0] seg; logic rst; } scan_t;
  typedef struct { logic [7:0] oe; logic [7:0] uout; logic [7:0] pad;
                   logic [7:0] exp_pad_o; logic [7:0] exp_in; } uio_t;
  scan_t scan_tab [7];
  uio_t  uio_tab [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic raw_bit(input int src, input int m);
    if (m < 1) return 1'b0;
    if (src == 2) return step_h[m];
    return sw_h[m][src];
  endfunction

  // Flip only if the raw input disagreed with prev throughout the window
  // seen by the synchroniser over the last DEB edges.
  function automatic logic debounced(input int src, input logic prev, input int nn);
    for (int k = 2; k <= DEB + 1; k++) begin
      if (raw_bit(src, nn - k) == prev) return prev;
    end
    return ~prev;
  endfunction

  function automatic logic [7:0] pmod_at(input int m);
    return (m < 1) ? 8'h00 : pmod_h[m];
  endfunction

  function automatic logic [7:0] pad_at(input int m);
    return (m < 1) ? 8'h00 : pad_h[m];
  endfunction

  function automatic logic sdb_at(input int m);
    return (m < 0) ? 1'b0 : sdb_h[m];
  endfunction

  task automatic model_and_check();
    logic [1:0] db;
    logic       r, ena_exp;
    int         d;
    logic [3:0] nib;
    db[0] = debounced(0, db_h[n-1][0], n);
    db[1] = debounced(1, db_h[n-1][1], n);
    db_h[n] = db;
    sdb_h[n] = debounced(2, sdb_h[n-1], n);
    r = (n >= STRETCH);
    for (int k = n - STRETCH; k < n; k++) begin
      if (k >= 0 && db_h[k][0]) r = 1'b0;
    end
    rst_h[n] = r;
`ifdef FPGA_TT_HARNESS_STEP_EN
    ena_exp = rst_h[n-1] & (db_h[n-1][1] | (sdb_h[n-1] & ~sdb_at(n - 2)));
`else
    ena_exp = rst_h[n-1] & db_h[n-1][1];
`endif
    if (n % REFR == 0) begin
      d = (n / REFR - 1) % ND;
      nib = disp_h[n][4*d +: 4];
      seg_m = ~hex_tab[nib];
      dig_m = ~(4'b0001 << d);
    end
    chk("ui_in", ui_in_o, pmod_at(n - 1));
    chk("uio_in", uio_in_o, pad_at(n - 2) & ~oe_h[n]);
    chk("uio_pad", uio_pad_o, uout & oe);
    chk("dut_rst_n", dut_rst_n_o, rst_h[n]);
    chk("dut_ena", dut_ena_o, ena_exp);
    chk("seg", seg_o, seg_m);
    chk("dig_sel", dig_sel_o, dig_m);
  endtask

  task automatic tick();
    int idx = n + 1;
    if (idx >= HN) begin
      $display("FAIL history_overflow: got %0d expected <%0d", idx, HN);
      $fatal(1, "history overflow");
    end
    sw_h[idx] = sw; step_h[idx] = step; pmod_h[idx] = pmod;
    pad_h[idx] = pad; oe_h[idx] = oe; disp_h[idx] = disp;
    @(posedge clk);
    n = idx;
    #1;
    model_and_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sw = '0; step = 1'b0; pmod = '0; pad = '0;
    uout = '0; oe = '0; disp = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dut_rst_n", dut_rst_n_o, 1'b0);
    chk("rst_dut_ena", dut_ena_o, 1'b0);
    chk("rst_ui_in", ui_in_o, 8'h00);
    chk("rst_uio_in", uio_in_o, 8'h00);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_dig", dig_sel_o, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; db_h[0] = '0; sdb_h[0] = 1'b0; rst_h[0] = 1'b0;
    seg_m = 7'h7F; dig_m = 4'hF;
  endtask

  initial begin
    int cnt, seen, hi;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    scan_tab[0] = '{3,  4'hF, 7'h7F,   1'b0};
    scan_tab[1] = '{4,  4'hE, ~7'h71,  1'b0};
    scan_tab[2] = '{8,  4'hD, ~7'h5B,  1'b0};
    scan_tab[3] = '{12, 4'hB, ~7'h77,  1'b0};
    scan_tab[4] = '{15, 4'hB, ~7'h77,  1'b0};
    scan_tab[5] = '{16, 4'h7, ~7'h06,  1'b1};
    scan_tab[6] = '{20, 4'hE, ~7'h71,  1'b1};
    uio_tab[0] = '{8'hF0, 8'hA5, 8'h3C, 8'hA0, 8'h0C};
    uio_tab[1] = '{8'h0F, 8'hA5, 8'h3C, 8'h05, 8'h30};
    uio_tab[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    uio_tab[3] = '{8'h00, 8'hFF, 8'hC3, 8'h00, 8'hC3};

    // Reset release and display scan of 0x1A2F.
    do_reset();
    disp = 16'h1A2F;
    for (int i = 0; i < 7; i++) begin
      while (n < scan_tab[i].at) tick();
      chk("scan_dig", dig_sel_o, scan_tab[i].dig);
      chk("scan_seg", seg_o, scan_tab[i].seg);
      chk("scan_rst", dut_rst_n_o, scan_tab[i].rst);
    end

    // sw[1] glitch shorter than the debounce window.
    seen = 0;
    sw[1] = 1'b1;
    repeat (5) begin tick(); if (dut_ena_o) seen = 1; end
    sw[1] = 1'b0;
    repeat (15) begin tick(); if (dut_ena_o) seen = 1; end
    chk("ena_glitch", seen, 0);

    // sw[1] held: enable rises 2+8+1 edges later.
    sw[1] = 1'b1;
    cnt = 0;
    while (!dut_ena_o && cnt < 40) begin tick(); cnt++; end
    chk("ena_latency", cnt, 11);
    repeat (9) tick();
    sw[1] = 1'b0;
    repeat (12) tick();

    // sw[0] press, release, then re-press while the stretch is running.
    sw[0] = 1'b1;
    repeat (12) tick();
    sw[0] = 1'b0;
    repeat (10) tick();
    chk("rst_held", dut_rst_n_o, 1'b0);
    sw[0] = 1'b1;
    repeat (8) tick();
    sw[0] = 1'b0;
    cnt = 0;
    while (!dut_rst_n_o && cnt < 60) begin tick(); cnt++; end
    chk("stretch_restart", cnt, 26);

    // uio pad vectors.
    for (int i = 0; i < 4; i++) begin
      oe = uio_tab[i].oe; uout = uio_tab[i].uout; pad = uio_tab[i].pad;
      repeat (3) tick();
      chk("uio_pad_vec", uio_pad_o, uio_tab[i].exp_pad_o);
      chk("uio_in_vec", uio_in_o, uio_tab[i].exp_in);
    end

    // Randomised traffic on every input.
    for (int i = 0; i < 1500; i++) begin
      pmod = 8'($urandom); pad = 8'($urandom); oe = 8'($urandom);
      uout = 8'($urandom); disp = 16'($urandom);
      if ($urandom_range(0, 19) == 0) sw[0] = ~sw[0];
      if ($urandom_range(0, 11) == 0) sw[1] = ~sw[1];
      if ($urandom_range(0, 9) == 0) step = ~step;
      tick();
    end

    // Asynchronous reset assertion mid-cycle.
    sw = '0; step = 1'b0;
    repeat (40) tick();
    chk("pre_async_rst", dut_rst_n_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dut_rst", dut_rst_n_o, 1'b0);
    chk("async_seg", seg_o, 7'h7F);
    do_reset();
    repeat (20) tick();

`ifdef FPGA_TT_HARNESS_STEP_EN
    // Three debounced presses with sw[1]=0 give three one-cycle enables.
    seen = 0; hi = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (12) begin tick(); if (dut_ena_o) hi++; end
      step = 1'b0;
      repeat (12) begin tick(); if (dut_ena_o) hi++; end
    end
    chk("step_high_cycles", hi, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpga_tt_harness.md
Name: fpga_tt_harness

Overview:
Parametrised board-side harness wrapping a TinyTapeout-style `top` for FPGA emulation; successor to the flat switch/pmod glue.
Adds:
- Switch synchronisation and debouncing.
- Stretched DUT reset.
- Bidirectional uio pad handling.
- Time-multiplexed N-digit hex seven-segment display.
Sits between board pins and the DUT instance in the FPGA top level.

Parameters:
NUM_SW, 2, number of raw switches (>=2); sw[0]=DUT reset request, sw[1]=DUT enable.
DEBOUNCE_CYCLES, 16'd50000, cycles a synced switch must differ from its stable value before the stable value flips (>=1).
RST_STRETCH, 16, cycles dut_rst_n_o stays low after all reset sources release (>=1).
NUM_DIGITS, 4, seven-segment digits driven (1..8).
REFRESH_CYCLES, 1000, cycles each digit is lit (>=2).
SEG_ACTIVE_LOW, 1, 1: segment and digit-select outputs active-low; 0: active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  board reset, asynchronous, active-low
- sw_i  in  NUM_SW  raw switches
- pmod_i  in  8  raw pmod inputs
- uio_pad_i  in  8  uio pad input values
- uio_pad_o  out  8  uio pad drive values
- ui_in_o  out  8  synchronised pmod to DUT ui_in
- uio_in_o  out  8  to DUT uio_in
- uio_out_i  in  8  from DUT uio_out
- uio_oe_i  in  8  from DUT uio_oe
- dut_rst_n_o  out  1  DUT reset
- dut_ena_o  out  1  DUT ena
- disp_val_i  in  4*NUM_DIGITS  value shown as hex; digit 0 = bits [3:0]
- seg_o  out  7  segments {g,f,e,d,c,b,a}
- dig_sel_o  out  NUM_DIGITS  one-hot digit select

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. All flops reset asynchronously on `rst_n` low.
- Reset values:
  - ui_in_o = 0, uio_in_o = 0, uio_pad_o = 0.
  - dut_rst_n_o = 0, dut_ena_o = 0.
  - All debounced switch states = 0.
  - Digit index = 0.
  - seg_o and dig_sel_o at the all-off level: all 1 if SEG_ACTIVE_LOW, else all 0.
- Synchronisers: sw_i, pmod_i and uio_pad_i each pass through a 2-flop synchroniser. ui_in_o is the pmod sync output, 2-cycle latency.
- uio handling:
  - uio_in_o = uio_pad sync output & ~uio_oe_i, registered; 3-cycle pad-to-DUT latency.
  - uio_pad_o = uio_out_i & uio_oe_i, combinational; undriven bits read 0.
- Debounce, per switch:
  - Counter clears whenever the synced value equals the stable value; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value flips next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change. DEBOUNCE_CYCLES=1 flips one cycle after sync.
- Reset stretcher:
  - dut_rst_n_o falls asynchronously with rst_n.
  - dut_rst_n_o falls on the edge after debounced sw[0] becomes 1.
  - Stretch counter clears while any source is active.
  - dut_rst_n_o rises on the edge where the counter reaches RST_STRETCH, i.e. RST_STRETCH cycles after the last source released.
  - Re-asserting a source mid-stretch restarts the count.
- Enable: dut_ena_o is registered as debounced sw[1] & dut_rst_n_o; forced 0 one cycle after reset assertion.
- Display:
  - Refresh counter runs 0..REFRESH_CYCLES-1, then wraps.
  - On wrap, the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - seg_o and dig_sel_o are registered together, so they change on the same edge.
  - The nibble is sampled from disp_val_i at that edge and hex-decoded 0-F (standard patterns; b and d lower case).
  - Polarity is applied per SEG_ACTIVE_LOW.
  - NUM_DIGITS=1 keeps the single digit permanently selected, with the nibble refreshed every period.

Optional Feature:
- Macro: FPGA_TT_HARNESS_STEP_EN.
- With the macro defined:
  - An extra input `step_i` (1 bit, raw button) is synchronised and debounced like the switches.
  - When debounced sw[1] = 0, each 0->1 edge of debounced step_i produces exactly one cycle of dut_ena_o = 1, provided dut_rst_n_o = 1.
  - When debounced sw[1] = 1, the DUT runs freely and step_i is ignored.
- Without the macro: no step_i port; dut_ena_o follows debounced sw[1] only.

Decomposition:
- Package fpga_tt_harness_pkg holds:
  - The hex-to-seven-segment constant table (16 x 7 bits, active-high).
  - SEG_OFF constant.
  - A clog2-based counter-width helper function.
- Sub-module fpga_tt_debounce: 2-flop sync + counter, one instance per switch (and for step_i).

Test Plan:
- Reset release: rst_n low 5 cycles then high, sw=0, RST_STRETCH=16 -> dut_rst_n_o rises exactly 16 cycles after rst_n deasserts; seg_o/dig_sel_o all-off until the first refresh.
- Debounce: DEBOUNCE_CYCLES=8.
  - sw[1] pulse of 5 cycles -> dut_ena_o stays 0.
  - Held 20 cycles -> dut_ena_o rises 2+8+1 cycles after the input edge.
- Mid-stretch re-assert: sw[0] debounced high for 1 cycle at stretch count 10 -> counter restarts; release occurs 16 cycles after the second release.
- uio pads: uio_oe_i=8'hF0, uio_out_i=8'hA5, uio_pad_i=8'h3C -> uio_pad_o=8'hA0; uio_in_o=8'h0C three cycles later.
- Display scan: NUM_DIGITS=4, REFRESH_CYCLES=4, disp_val_i=16'h1A2F, active-low -> dig_sel_o cycles 1110, 1101, 1011, 0111 every 4 cycles with seg_o = ~F, ~2, ~A, ~1 patterns; 0111 wraps back to 1110.
- Step (FPGA_TT_HARNESS_STEP_EN): sw[1]=0, three debounced step_i presses -> exactly three single-cycle dut_ena_o pulses.
